// File: rtl/spk_out_pkg.sv
// Shared flit-type constants and arbiter state encoding for the spike-out FIFO writer.
package spk_out_pkg;

  localparam int FTW = 3;

  localparam logic [FTW-1:0] SPIKE    = 3'b000;
  localparam logic [FTW-1:0] DATA     = 3'b001;
  localparam logic [FTW-1:0] DATA_END = 3'b010;
  localparam logic [FTW-1:0] WRITE    = 3'b110;
  localparam logic [FTW-1:0] READ     = 3'b111;

  typedef enum logic [0:0] {
    S_IDLE     = 1'b0,
    S_CFG_LOCK = 1'b1
  } arb_state_t;

  function automatic logic opens_lock(input logic [FTW-1:0] i_type);
    return (i_type == DATA);
  endfunction

  function automatic logic closes_lock(input logic [FTW-1:0] i_type);
    return (i_type == DATA_END);
  endfunction

endpackage

// File: rtl/spk_out_arb_queue.sv
// Synchronous first-word-fall-through FIFO; full/empty come straight off the count register,
// so a pop in the same cycle never unblocks that cycle's push.
module spk_out_arb_queue #(
  parameter int W = 59,
  parameter int D = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [W-1:0]           i_wdata,
  input  logic                   i_pop,
  output logic [W-1:0]           o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(D):0]     o_count
);

  localparam int AW = $clog2(D);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [D];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CW'(D));
  assign o_empty   = (r_count == {CW{1'b0}});
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally since D is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= {AW{1'b0}};
      r_rptr  <= {AW{1'b0}};
      r_count <= {CW{1'b0}};
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/spk_out_arb.sv
// Spike-out FIFO writer: queues soma spikes and config flits, keeps DATA..DATA_END packets
// contiguous and bounds config starvation. Drop statistics exist only with SPK_OUT_ARB_STAT_EN.
module spk_out_arb #(
  parameter int FW         = 59,
  parameter int SW         = 24,
  parameter int SPK_QD     = 4,
  parameter int CFG_QD     = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          soma_spk_out_fire,
  input  logic [SW-1:0] soma_neuid,
  output logic          spk_out_soma_busy,
  input  logic          config_spk_out_we,
  input  logic [FW-1:0] config_spk_out_wdata,
  output logic          spk_out_config_full,
  input  logic          spk_out_fifo_full,
  output logic          spk_out_push,
  output logic [FW-1:0] spk_out_push_data,
  output logic [15:0]   stat_spk_drop,
  output logic [15:0]   stat_cfg_drop
);

  import spk_out_pkg::*;

  localparam int SCW = $clog2(STARVE_MAX + 1);
  localparam logic [SCW-1:0] STARVE_LIM = SCW'(STARVE_MAX);

  arb_state_t             r_state;
  logic [SCW-1:0]         r_starve;
  logic                   r_push;
  logic [FW-1:0]          r_push_data;
  logic [FW-1:0]          w_spk_flit;
  logic [FW-1:0]          w_spk_head;
  logic [FW-1:0]          w_cfg_head;
  logic                   w_spk_full, w_spk_empty, w_cfg_full, w_cfg_empty;
  logic [$clog2(SPK_QD):0] w_spk_count;
  logic [$clog2(CFG_QD):0] w_cfg_count;
  logic                   w_spk_grant, w_cfg_grant, w_spk_pop, w_cfg_pop, w_issue;
  logic [FTW-1:0]         w_cfg_type;
  logic                   w_unused_counts;

  assign w_spk_flit = {SPIKE, {(FW-SW-FTW){1'b0}}, soma_neuid};
  assign w_cfg_type = w_cfg_head[FW-1 -: FTW];
  // Occupancy counts are exposed by the queue for debug; arbitration needs only full/empty.
  assign w_unused_counts = ^{w_spk_count, w_cfg_count};

  spk_out_arb_queue #(.W(FW), .D(SPK_QD)) u_spk_q (
    .clk(clk), .rst_n(rst_n),
    .i_push(soma_spk_out_fire), .i_wdata(w_spk_flit), .i_pop(w_spk_pop),
    .o_head(w_spk_head), .o_full(w_spk_full), .o_empty(w_spk_empty), .o_count(w_spk_count)
  );

  spk_out_arb_queue #(.W(FW), .D(CFG_QD)) u_cfg_q (
    .clk(clk), .rst_n(rst_n),
    .i_push(config_spk_out_we), .i_wdata(config_spk_out_wdata), .i_pop(w_cfg_pop),
    .o_head(w_cfg_head), .o_full(w_cfg_full), .o_empty(w_cfg_empty), .o_count(w_cfg_count)
  );

  // Grant selection: spikes win in idle until the waiting config head has been starved too long.
  always_comb begin
    w_spk_grant = 1'b0;
    w_cfg_grant = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_spk_empty && (r_starve < STARVE_LIM)) begin
          w_spk_grant = 1'b1;
        end else begin
          w_cfg_grant = !w_cfg_empty;
        end
      end
      S_CFG_LOCK: w_cfg_grant = !w_cfg_empty;
      default: begin
        w_spk_grant = 1'b0;
        w_cfg_grant = 1'b0;
      end
    endcase
  end

  assign w_spk_pop = w_spk_grant && !spk_out_fifo_full;
  assign w_cfg_pop = w_cfg_grant && !spk_out_fifo_full;
  assign w_issue   = w_spk_pop || w_cfg_pop;

  // Arbiter FSM, starvation counter and registered FIFO write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_starve    <= {SCW{1'b0}};
      r_push      <= 1'b0;
      r_push_data <= {FW{1'b0}};
    end else begin
      r_push <= w_issue;
      if (w_issue) begin
        r_push_data <= w_cfg_pop ? w_cfg_head : w_spk_head;
      end
      case (r_state)
        S_IDLE:     if (w_cfg_pop && opens_lock(w_cfg_type))  r_state <= S_CFG_LOCK;
        S_CFG_LOCK: if (w_cfg_pop && closes_lock(w_cfg_type)) r_state <= S_IDLE;
        default:    r_state <= S_IDLE;
      endcase
      // Backpressure freezes the counter along with everything else.
      if (!spk_out_fifo_full) begin
        if (w_cfg_empty || w_cfg_pop) begin
          r_starve <= {SCW{1'b0}};
        end else if (w_spk_pop && (r_starve != STARVE_LIM)) begin
          r_starve <= r_starve + SCW'(1);
        end
      end
    end
  end

  assign spk_out_soma_busy   = w_spk_full;
  assign spk_out_config_full = w_cfg_full;
  assign spk_out_push        = r_push;
  assign spk_out_push_data   = r_push_data;

`ifdef SPK_OUT_ARB_STAT_EN
  logic [15:0] r_stat_spk;
  logic [15:0] r_stat_cfg;

  // Saturating drop counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stat_spk <= 16'h0000;
      r_stat_cfg <= 16'h0000;
    end else begin
      if (soma_spk_out_fire && w_spk_full && (r_stat_spk != 16'hFFFF)) r_stat_spk <= r_stat_spk + 16'h0001;
      if (config_spk_out_we && w_cfg_full && (r_stat_cfg != 16'hFFFF)) r_stat_cfg <= r_stat_cfg + 16'h0001;
    end
  end

  assign stat_spk_drop = r_stat_spk;
  assign stat_cfg_drop = r_stat_cfg;
`else
  assign stat_spk_drop = 16'h0000;
  assign stat_cfg_drop = 16'h0000;
`endif

endmodule

// File: tb/tb_spk_out_arb.sv
// Randomized and directed bench for spk_out_arb against a queue-based reference model.
module tb_spk_out_arb;
  import spk_out_pkg::*;

  localparam int FW = 59;
  localparam int SW = 24;
  localparam int QD = 4;
  localparam int SMAX = 8;

  logic          clk = 1'b0;
  logic          rst_n, fire, we, ffull;
  logic [SW-1:0] neuid;
  logic [FW-1:0] wdata;
  logic          busy, cfull, push;
  logic [FW-1:0] push_data;
  logic [15:0]   st_spk, st_cfg;

  int n_total = 0;
  int n_bad   = 0;

  // reference model state
  logic [FW-1:0] m_spk[$];
  logic [FW-1:0] m_cfg[$];
  bit            m_lock;
  int            m_starve;
  logic          m_push;
  logic [FW-1:0] m_data;
  int            m_st_spk, m_st_cfg;

  spk_out_arb #(.FW(FW), .SW(SW), .SPK_QD(QD), .CFG_QD(QD), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .soma_spk_out_fire(fire), .soma_neuid(neuid), .spk_out_soma_busy(busy),
    .config_spk_out_we(we), .config_spk_out_wdata(wdata), .spk_out_config_full(cfull),
    .spk_out_fifo_full(ffull), .spk_out_push(push), .spk_out_push_data(push_data),
    .stat_spk_drop(st_spk), .stat_cfg_drop(st_cfg)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, then compare every output after the edge.
  task automatic step(input logic r, input logic f, input logic [SW-1:0] nid,
                      input logic w, input logic [FW-1:0] wd, input logic ff);
    int  kind;
    bit  cfg_ne, was_busy, was_cfull;
    logic [FW-1:0] d;
    @(negedge clk);
    rst_n = r; fire = f; neuid = nid; we = w; wdata = wd; ffull = ff;
    if (!r) begin
      m_spk.delete(); m_cfg.delete();
      m_lock = 0; m_starve = 0; m_push = 0; m_data = '0; m_st_spk = 0; m_st_cfg = 0;
    end else begin
      was_busy  = (m_spk.size() == QD);
      was_cfull = (m_cfg.size() == QD);
      cfg_ne    = (m_cfg.size() != 0);
      kind = 0;
      if (!ff) begin
        if (m_lock) begin
          if (cfg_ne) kind = 2;
        end else if (m_spk.size() != 0 && m_starve < SMAX) kind = 1;
        else if (cfg_ne) kind = 2;
      end
      m_push = (kind != 0);
      if (kind == 1) begin
        m_data = m_spk.pop_front();
      end else if (kind == 2) begin
        d = m_cfg.pop_front();
        m_data = d;
        if (d[FW-1 -: 3] == DATA) m_lock = 1;
        else if (d[FW-1 -: 3] == DATA_END) m_lock = 0;
      end
      if (!ff) begin
        if (!cfg_ne || kind == 2) m_starve = 0;
        else if (kind == 1 && m_starve < SMAX) m_starve++;
      end
      if (f) begin
        if (!was_busy) m_spk.push_back({3'b000, 32'h0, nid});
        else if (m_st_spk < 16'hFFFF) m_st_spk++;
      end
      if (w) begin
        if (!was_cfull) m_cfg.push_back(wd);
        else if (m_st_cfg < 16'hFFFF) m_st_cfg++;
      end
    end
    @(posedge clk);
    #1;
    check_eq("push", push, m_push);
    check_eq("push_data", push_data, m_data);
    check_eq("busy", busy, m_spk.size() == QD);
    check_eq("config_full", cfull, m_cfg.size() == QD);
`ifdef SPK_OUT_ARB_STAT_EN
    check_eq("stat_spk", st_spk, m_st_spk);
    check_eq("stat_cfg", st_cfg, m_st_cfg);
`else
    check_eq("stat_spk", st_spk, 16'h0000);
    check_eq("stat_cfg", st_cfg, 16'h0000);
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic reset_dut();
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    check_eq("rst_push", push, 1'b0);
    check_eq("rst_data", push_data, 59'h0);
  endtask

  initial begin
    logic [FW-1:0] flit;
    int  spikes, t0, t1;
    bit  done, seen_end;

    rst_n = 1'b0; fire = 1'b0; we = 1'b0; ffull = 1'b0; neuid = '0; wdata = '0;

    // basic latency
    reset_dut();
    idle(1);
    step(1'b1, 1'b1, 24'h012345, 1'b0, '0, 1'b0);
    check_eq("lat_not_early", push, 1'b0);
    idle(1);
    check_eq("lat_push", push, 1'b1);
    check_eq("lat_data", push_data, 59'h0000_0000_0012345);

    // simultaneous fire and config write
    idle(2);
    step(1'b1, 1'b1, 24'h000005, 1'b1, 59'h6_0000_0000_00AB, 1'b0);
    idle(1);
    check_eq("same_spk", push_data, 59'h5);
    idle(1);
    check_eq("same_cfg", push_data, 59'h6_0000_0000_00AB);
    idle(2);

    // starvation bound
    reset_dut();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 24'(i), 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 24'h100, 1'b1, {WRITE, 56'h77}, 1'b0);
    spikes = 0; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      step(1'b1, 1'b1, 24'(200 + i), 1'b0, '0, 1'b0);
      if (push) begin
        if (push_data[FW-1 -: 3] == WRITE) done = 1;
        else spikes++;
      end
    end
    check_eq("starve_done", done, 1'b1);
    check_eq("starve_spikes", spikes, SMAX);
    idle(8);

    // DATA..DATA_END packet stays contiguous under constant spike pressure
    reset_dut();
    step(1'b1, 1'b1, 24'h1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 24'h2, 1'b1, {DATA, 56'hA1}, 1'b0);
    step(1'b1, 1'b1, 24'h3, 1'b1, {DATA, 56'hA2}, 1'b0);
    step(1'b1, 1'b1, 24'h4, 1'b1, {DATA_END, 56'hA3}, 1'b0);
    t0 = 0; t1 = 0; seen_end = 0; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      step(1'b1, 1'b1, 24'(16 + i), 1'b0, '0, 1'b0);
      if (push) begin
        if (seen_end) begin
          check_eq("lock_spk_resume", push_data[FW-1 -: 3], SPIKE);
          done = 1;
        end else if (push_data[FW-1 -: 3] == DATA_END) begin
          check_eq("lock_contig", {t1[2:0], t0[2:0]}, {DATA, DATA});
          seen_end = 1;
        end
        t1 = t0; t0 = int'(push_data[FW-1 -: 3]);
      end
    end
    check_eq("lock_done", done, 1'b1);
    idle(8);

    // backpressure, queue-full flags and drop statistics
    reset_dut();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, i < 7, 24'hA00000 + 24'(i), i < 6, {WRITE, 56'(i)}, 1'b1);
      check_eq("bp_no_push", push, 1'b0);
    end
    check_eq("bp_busy", busy, 1'b1);
    check_eq("bp_cfull", cfull, 1'b1);
`ifdef SPK_OUT_ARB_STAT_EN
    check_eq("bp_stat_spk", st_spk, 16'd3);
    check_eq("bp_stat_cfg", st_cfg, 16'd2);
`endif
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    check_eq("bp_release", push, 1'b1);
    check_eq("bp_release_data", push_data, 59'hA00000);
    idle(12);

    // reset while locked
    reset_dut();
    step(1'b1, 1'b0, '0, 1'b1, {DATA, 56'h5}, 1'b0);
    step(1'b1, 1'b1, 24'h9, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 24'hA, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 24'hB, 1'b1, {DATA, 56'h6}, 1'b0);
    check_eq("midlock_push", push, 1'b0);
    check_eq("midlock_busy", busy, 1'b0);
    check_eq("midlock_stat", st_spk, 16'h0);
    step(1'b1, 1'b1, 24'hC, 1'b0, '0, 1'b0);
    idle(1);
    check_eq("midlock_idle_spk", push_data, 59'hC);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      flit = {3'($urandom_range(0, 7)), 24'($urandom), 32'($urandom)};
      step(1'b1, $urandom_range(0, 9) < 6, 24'($urandom), $urandom_range(0, 9) < 3,
           flit, $urandom_range(0, 9) < 2);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
